// File: rtl/stream_max_min.sv
// Streaming extremum tracker: running max/min with first-occurrence indices over a frame.
// Optional two's-complement compare when STREAM_MAXMIN_SIGNED_EN is defined.
module stream_max_min #(
  parameter  int N     = 5,
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  input  logic          signed_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  max_val,
  output logic [N-1:0]  min_val,
  output logic [IW-1:0] max_idx,
  output logic [IW-1:0] min_idx,
  output logic [IW:0]   count,
  output logic          overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [IW:0] LAST_K  = (IW+1)'(DEPTH - 1);
  localparam logic [IW:0] CNT_ONE = (IW+1)'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  max_q, max_d, min_q, min_d;
  logic [IW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic [IW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          accept, frame_end, cmp_sm;

  // a < b decided by the borrow of an N+1-bit subtraction; MSB flip maps signed onto unsigned order
  function automatic logic lt(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    logic [N:0] diff;
    diff = {1'b0, a ^ {sm, {(N-1){1'b0}}}} - {1'b0, b ^ {sm, {(N-1){1'b0}}}};
    return diff[N];
  endfunction

`ifdef STREAM_MAXMIN_SIGNED_EN
  logic smode_q, smode_d;

  always_comb begin
    smode_d = smode_q;
    if (state_q == S_IDLE && accept) smode_d = signed_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smode_q <= 1'b0;
    else        smode_q <= smode_d;
  end

  assign cmp_sm = smode_q;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign cmp_sm = 1'b0;
`endif

  assign accept    = in_valid && (state_q != S_DONE);
  assign frame_end = in_last || (count_q == LAST_K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DONE : S_ACC;
      S_ACC:   if (accept && frame_end) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
  end

  // Ties leave the stored extremum alone, so the earliest index wins
  always_comb begin
    max_d      = max_q;
    min_d      = min_q;
    max_idx_d  = max_idx_q;
    min_idx_d  = min_idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: if (accept) begin
        max_d      = in_data;
        min_d      = in_data;
        max_idx_d  = '0;
        min_idx_d  = '0;
        count_d    = CNT_ONE;
        overflow_d = 1'b0;
      end
      S_ACC: if (accept) begin
        if (lt(max_q, in_data, cmp_sm)) begin
          max_d     = in_data;
          max_idx_d = count_q[IW-1:0];
        end
        if (lt(in_data, min_q, cmp_sm)) begin
          min_d     = in_data;
          min_idx_d = count_q[IW-1:0];
        end
        count_d    = count_q + CNT_ONE;
        overflow_d = (count_q == LAST_K) && !in_last;
      end
      S_DONE: if (out_ready) overflow_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q      <= '0;
      min_q      <= '0;
      max_idx_q  <= '0;
      min_idx_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      max_q      <= max_d;
      min_q      <= min_d;
      max_idx_q  <= max_idx_d;
      min_idx_q  <= min_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = max_idx_q;
  assign min_idx  = min_idx_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stream_max_min.sv
// Bench for stream_max_min: directed frames plus randomized frames against a queue-based model.
module tb_stream_max_min;
  localparam int N     = 5;
  localparam int DEPTH = 8;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, signed_mode, out_ready;
  logic [N-1:0]  in_data;
  logic          in_ready, out_valid, overflow;
  logic [N-1:0]  max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;
  logic [IW:0]   count;

  stream_max_min dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .max_val(max_val),
    .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int frm[$];
  bit frm_last;
  bit frm_sm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Numeric value of a sample under the frame's compare mode
  function automatic int sval(input int x, input bit sm);
`ifdef STREAM_MAXMIN_SIGNED_EN
    if (sm && x >= (1 << (N-1))) return x - (1 << N);
`endif
    return x;
  endfunction

  task automatic drive_frame();
    for (int i = 0; i < frm.size(); i++) begin
      in_valid    = 1'b1;
      in_data     = N'(frm[i]);
      in_last     = frm_last && (i == frm.size() - 1);
      signed_mode = (i == 0) ? frm_sm : ~frm_sm;
      check("in_ready_acc", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (i < frm.size() - 1) check("out_valid_mid", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int mx_i, mn_i;
    mx_i = 0;
    mn_i = 0;
    for (int i = 1; i < frm.size(); i++) begin
      if (sval(frm[i], frm_sm) > sval(frm[mx_i], frm_sm)) mx_i = i;
      if (sval(frm[i], frm_sm) < sval(frm[mn_i], frm_sm)) mn_i = i;
    end
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".in_ready"},  {31'b0, in_ready},  32'd0);
    check({tag, ".max_val"},   32'(max_val), 32'(frm[mx_i]));
    check({tag, ".max_idx"},   32'(max_idx), 32'(mx_i));
    check({tag, ".min_val"},   32'(min_val), 32'(frm[mn_i]));
    check({tag, ".min_idx"},   32'(min_idx), 32'(mn_i));
    check({tag, ".count"},     32'(count),   32'(frm.size()));
    check({tag, ".overflow"},  {31'b0, overflow},
          (frm.size() == DEPTH && !frm_last) ? 32'd1 : 32'd0);
  endtask

  // Hold the result for 'hold' cycles with junk on the input, then hand it off
  task automatic drain(input string tag, input int hold);
    logic [N-1:0] mx0;
    logic [IW:0]  cnt0;
    mx0  = max_val;
    cnt0 = count;
    out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom_range(0, 31));
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".hold_ready"}, {31'b0, in_ready},  32'd0);
      check({tag, ".hold_max"},   32'(max_val), 32'(mx0));
      check({tag, ".hold_count"}, 32'(count),   32'(cnt0));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".post_ready"}, {31'b0, in_ready},  32'd1);
    check({tag, ".post_ovf"},   {31'b0, overflow},  32'd0);
    check({tag, ".post_count"}, 32'(count),   32'(cnt0));
    check({tag, ".post_max"},   32'(max_val), 32'(mx0));
  endtask

  task automatic run_frame(input string tag, input int hold);
    drive_frame();
    check_result(tag);
    drain(tag, hold);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"},  {31'b0, in_ready},  32'd1);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".overflow"},  {31'b0, overflow},  32'd0);
    check({tag, ".max_val"},   32'(max_val), 32'd0);
    check({tag, ".min_val"},   32'(min_val), 32'd0);
    check({tag, ".max_idx"},   32'(max_idx), 32'd0);
    check({tag, ".min_idx"},   32'(min_idx), 32'd0);
    check({tag, ".count"},     32'(count),   32'd0);
  endtask

  initial begin
    int len, lim;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    signed_mode = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_vals("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    frm = '{3, 17, 9, 31, 0};   frm_last = 1; frm_sm = 0; run_frame("basic", 0);
    frm = '{7, 7, 2, 2};        frm_last = 1; frm_sm = 0; run_frame("ties", 1);
    frm = '{31, 3, 16};         frm_last = 1; frm_sm = 1; run_frame("signed", 0);
    frm = '{31, 3, 16};         frm_last = 1; frm_sm = 0; run_frame("unsigned3", 0);
    frm = '{1, 2, 3, 4, 5, 6, 7, 8}; frm_last = 0; frm_sm = 0; run_frame("ovf", 0);
    frm = '{1, 2, 3, 4, 5, 6, 7, 8}; frm_last = 1; frm_sm = 0; run_frame("full_last", 0);
    frm = '{20, 5, 9};          frm_last = 1; frm_sm = 0; run_frame("backpressure", 5);
    frm = '{9};                 frm_last = 1; frm_sm = 1; run_frame("single", 0);

    // Reset after 3 of 5 samples
    frm = '{4, 8, 15, 16, 23};  frm_last = 1; frm_sm = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = N'(frm[i]); in_last = 1'b0; signed_mode = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frm = '{12};                frm_last = 1; frm_sm = 0; run_frame("after_reset", 0);

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, DEPTH);
      lim = ($urandom_range(0, 1) == 0) ? 3 : 31;
      frm = {};
      for (int i = 0; i < len; i++) frm.push_back(int'($urandom_range(0, lim)));
      frm_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      frm_sm   = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
